// File: rtl/blockmem_2p_rd_pkg.sv
// blockmem_2p_rd_pkg: shared state type and address wrap helper for the port-B read engine
package blockmem_2p_rd_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t;
  function automatic logic [31:0] f_addr_inc(input logic [31:0] addr, input logic [31:0] depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction
endpackage

// File: rtl/blockmem_rd_fifo.sv
// blockmem_rd_fifo: show-ahead FIFO buffering read words (data plus last bit) for the output stream
module blockmem_rd_fifo #(
  parameter int G_WIDTH = 33,
  parameter int G_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr,
  input  logic [G_WIDTH-1:0]       wdata,
  input  logic                     rd,
  output logic [G_WIDTH-1:0]       rdata,
  output logic                     empty,
  output logic [$clog2(G_DEPTH):0] count
);
  localparam int AW = $clog2(G_DEPTH);
  logic [G_WIDTH-1:0] mem [G_DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  assign empty = count == '0;
  // Head is forced to zero when empty so the stream outputs read as zero after reset
  assign rdata = empty ? '0 : mem[rp];
endmodule

// File: rtl/blockmem_2p_rd_stream.sv
// blockmem_2p_rd_stream: burst read engine for blockmem_2p port B with a credit-checked valid/ready output
module blockmem_2p_rd_stream
  import blockmem_2p_rd_pkg::*;
#(
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_ADDRWIDTH = $clog2(G_MEMDEPTH),
  parameter int G_RDLATENCY = 1,
  parameter int G_FIFODEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [G_ADDRWIDTH-1:0] req_addr,
  input  logic [G_ADDRWIDTH-1:0] req_len,
  output logic                   enb,
  output logic [G_ADDRWIDTH-1:0] addrb,
  input  logic [G_DATAWIDTH-1:0] doutb,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [G_DATAWIDTH-1:0] m_data,
  output logic                   m_last,
  output logic                   busy
);
  localparam int CW = $clog2(G_FIFODEPTH) + 1;
  rd_state_t state, state_nxt;
  logic [G_ADDRWIDTH-1:0] addr, len;
  logic [G_ADDRWIDTH:0] issue_cnt;
  logic [G_RDLATENCY-1:0] inflight, inflight_last;
  logic [CW-1:0] fifo_count;
  logic [G_DATAWIDTH:0] head;
  logic fifo_empty, issue_last, pop, accept;
  int pending;
  assign req_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign accept     = req_valid && req_ready;
  assign issue_last = issue_cnt == {1'b0, len};
  assign addrb      = addr;
  assign m_valid    = !fifo_empty;
  assign {m_last, m_data} = head;
  assign pop        = m_valid && m_ready;
  // Every word already buffered or still in the memory pipeline holds a FIFO slot
  always_comb begin
    pending = int'(fifo_count);
    for (int i = 0; i < G_RDLATENCY; i++) pending = pending + int'(inflight[i]);
    enb = (state == ISSUE) && (pending < G_FIFODEPTH);
  end
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid) state_nxt = ISSUE;
      ISSUE:   if (enb && issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      addr          <= '0;
      len           <= '0;
      issue_cnt     <= '0;
      inflight      <= '0;
      inflight_last <= '0;
    end else begin
      if (accept) begin
        addr      <= req_addr;
        len       <= req_len;
        issue_cnt <= '0;
      end else if (enb) begin
        addr      <= G_ADDRWIDTH'(f_addr_inc(32'(addr), 32'(G_MEMDEPTH)));
        issue_cnt <= issue_cnt + (G_ADDRWIDTH+1)'(1);
      end
      inflight      <= (inflight << 1) | G_RDLATENCY'(enb);
      inflight_last <= (inflight_last << 1) | G_RDLATENCY'(enb && issue_last);
    end
  blockmem_rd_fifo #(
    .G_WIDTH(G_DATAWIDTH + 1),
    .G_DEPTH(G_FIFODEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .wr    (inflight[G_RDLATENCY-1]),
    .wdata ({inflight_last[G_RDLATENCY-1], doutb}),
    .rd    (pop),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_blockmem_2p_rd_stream.sv
// tb_blockmem_2p_rd_stream: directed bench for the read engine at read latency 1 (dut 0) and 2 (dut 1)
module tb_blockmem_2p_rd_stream;
  localparam int DW = 32, MD = 1024, AW = 10, FD = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic          resetn [2];
  logic          req_valid [2];
  logic          req_ready [2];
  logic [AW-1:0] req_addr [2];
  logic [AW-1:0] req_len [2];
  logic          enb [2];
  logic [AW-1:0] addrb [2];
  logic          m_valid [2];
  logic          m_ready [2];
  logic [DW-1:0] m_data [2];
  logic          m_last [2];
  logic          busy [2];
  int tests = 0, fails = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] s1, s2;
    // Memory model holding mem[i] = i; a second register stage gives read latency 2
    always_ff @(posedge clk) begin
      if (enb[g]) s1 <= DW'(addrb[g]);
      s2 <= s1;
    end
    blockmem_2p_rd_stream #(
      .G_DATAWIDTH(DW), .G_MEMDEPTH(MD), .G_RDLATENCY(g + 1), .G_FIFODEPTH(FD)
    ) dut (
      .clk(clk), .resetn(resetn[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_addr(req_addr[g]), .req_len(req_len[g]),
      .enb(enb[g]), .addrb(addrb[g]), .doutb(g == 0 ? s1 : s2),
      .m_valid(m_valid[g]), .m_ready(m_ready[g]), .m_data(m_data[g]),
      .m_last(m_last[g]), .busy(busy[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue_req(input int d, input logic [AW-1:0] a, input logic [AW-1:0] l);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    req_len[d]   = l;
    for (int i = 0; i < 50 && !req_ready[d]; i++) @(negedge clk);
    chk("req_accept", req_ready[d], 1);
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  // Entered at the first falling edge after the accepting edge; mode 1 throttles m_ready
  task automatic collect(input int d, input logic [AW-1:0] a, input int l, input int mode);
    int first = -1, got = 0, issued = 0, last_k = -1;
    logic stalled = 1'b0, done = 1'b0, held_l = 1'b0;
    logic [DW-1:0] held_d = '0;
    logic [AW-1:0] ea = a;
    for (int k = 0; k < 300 && !done; k++) begin
      if (k > 0) @(negedge clk);
      m_ready[d] = (mode == 0) ? 1'b1 : (k < 12) ? (k % 3 == 2) : (k >= 32);
      if (stalled) begin
        chk("hold_data", m_data[d], held_d);
        chk("hold_last", m_last[d], held_l);
      end
      chk("req_ready_busy", req_ready[d], 0);
      chk("busy", busy[d], 1);
      if (enb[d]) begin
        chk("credit", issued - got >= FD, 0);
        chk("addrb", addrb[d], ea);
        ea = (ea == AW'(MD - 1)) ? '0 : ea + 1'b1;
        issued++;
      end
      if (m_valid[d] && first < 0) first = k;
      if (m_valid[d] && m_ready[d]) begin
        chk("data", m_data[d], DW'((int'(a) + got) % MD));
        chk("last", m_last[d], got == l);
        if (got == l) begin
          done = 1'b1;
          last_k = k;
        end
        got++;
      end
      if (mode == 1 && k == 31) begin
        chk("full_stall_enb", enb[d], 0);
        chk("full_valid", m_valid[d], 1);
      end
      stalled = m_valid[d] && !m_ready[d];
      held_d = m_data[d];
      held_l = m_last[d];
    end
    chk("done", done, 1);
    chk("first_valid", first, d + 2);
    chk("issued", issued, l + 1);
    if (mode == 0) chk("consecutive", last_k - first, l);
    @(negedge clk);
    chk("busy_end", busy[d], 0);
    chk("req_ready_end", req_ready[d], 1);
    chk("m_valid_end", m_valid[d], 0);
    m_ready[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = '0; req_len[d] = '0; m_ready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", req_ready[d], 1);
      chk("rst_enb", enb[d], 0);
      chk("rst_addrb", addrb[d], 0);
      chk("rst_m_valid", m_valid[d], 0);
      chk("rst_m_data", m_data[d], 0);
      chk("rst_m_last", m_last[d], 0);
      chk("rst_busy", busy[d], 0);
      resetn[d] = 1'b1;
    end
    // Simple burst, address wrap, throttled consumer
    issue_req(0, 10'h010, 3);
    collect(0, 10'h010, 3, 0);
    issue_req(0, 10'h3FE, 3);
    collect(0, 10'h3FE, 3, 0);
    issue_req(0, 10'h000, 15);
    collect(0, 10'h000, 15, 1);
    // Second request queued behind the first
    issue_req(0, 10'h040, 1);
    req_valid[0] = 1'b1;
    req_addr[0]  = 10'h080;
    req_len[0]   = 10'd2;
    collect(0, 10'h040, 1, 0);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("b2b_busy", busy[0], 1);
    collect(0, 10'h080, 2, 0);
    // Reset with the credit window exhausted
    issue_req(0, 10'h200, 15);
    repeat (4) @(negedge clk);
    chk("pre_rst_enb", enb[0], 0);
    chk("pre_rst_valid", m_valid[0], 1);
    resetn[0] = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_ready", req_ready[0], 1);
    @(negedge clk);
    chk("post_rst_valid", m_valid[0], 0);
    chk("post_rst_busy", busy[0], 0);
    chk("post_rst_ready", req_ready[0], 1);
    resetn[0] = 1'b1;
    issue_req(0, 10'h300, 2);
    collect(0, 10'h300, 2, 0);
    // Read latency 2
    issue_req(1, 10'h010, 3);
    collect(1, 10'h010, 3, 0);
    issue_req(1, 10'h000, 15);
    collect(1, 10'h000, 15, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
